video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; HS_POL 0; VS_POL 0 (0 = active-low sync).
REQ-002 Derived constants: H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525.
REQ-003 i_clk  input  1  pixel clock; all logic on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_en  input  1  pixel advance enable; low = stall.
REQ-006 o_hsync  output  1  horizontal sync at HS_POL.
REQ-007 o_vsync  output  1  vertical sync at VS_POL.
REQ-008 o_blank  output  1  1 = outside active area.
REQ-009 o_pixel_pos  output  21  linear raster index v*H_TOTAL+h, 0..419999.
REQ-010 o_line_start  output  1  one-cycle pulse at h=0 of every line.
REQ-011 o_frame_start  output  1  one-cycle pulse at h=0,v=0.

Function
REQ-012 Internal h_cnt (10 bit) counts 0..H_TOTAL-1; v_cnt (10 bit) counts 0..V_TOTAL-1.
REQ-013 When i_en=1: h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments in the same cycle.
REQ-014 v_cnt wraps from V_TOTAL-1 to 0 exactly when h_cnt wraps from H_TOTAL-1 (end of frame).
REQ-015 When i_en=0: counters, o_pixel_pos, o_hsync, o_vsync and o_blank hold; o_line_start and o_frame_start forced 0.
REQ-016 o_pixel_pos is a separate incrementing counter, not a multiplier; +1 per enabled cycle, wraps 419999 -> 0 coincident with v_cnt wrap.
REQ-017 All outputs registered; outputs in cycle n reflect counter state (h,v) after the enabled update in cycle n-1 (one-cycle latency, fixed).
REQ-018 o_blank = 0 iff h < H_ACTIVE and v < V_ACTIVE.
REQ-019 Horizontal sync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751); o_hsync = HS_POL when active, else ~HS_POL.
REQ-020 Vertical sync active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), across full lines irrespective of h; o_vsync = VS_POL when active, else ~VS_POL.
REQ-021 o_line_start = 1 for one enabled cycle when presented h = 0; o_frame_start = 1 when presented h = 0 and v = 0.
REQ-022 o_pixel_pos always equals v*H_TOTAL+h of the presented (h,v); consistency checked every enabled cycle.
REQ-023 Stall mid-line or mid-sync: pulse widths in enabled cycles unchanged; no sample skipped or repeated.

Reset
REQ-024 i_rst=1 at a clock edge: h_cnt=0, v_cnt=0, pixel counter=0; overrides i_en.
REQ-025 Outputs while in reset: o_hsync=~HS_POL, o_vsync=~VS_POL, o_blank=1, o_pixel_pos=0, o_line_start=0, o_frame_start=0.
REQ-026 First enabled cycle after release presents (0,0): o_blank=0, o_pixel_pos=0, o_line_start=1, o_frame_start=1.
REQ-027 Reset asserted mid-frame aborts frame; restart is identical to power-on sequence.

Verification
REQ-028 Reset then i_en=1 for 420000 cycles -> exactly one o_frame_start, 525 o_line_start, 307200 cycles o_blank=0, final o_pixel_pos=419999.
REQ-029 Line 0 -> o_blank=0 for pos 0..639, 1 for 640..799; o_hsync=0 for exactly 96 cycles starting at pos 656.
REQ-030 Frame scan -> o_vsync=0 for exactly 1600 cycles, from pos 392000 through 393599.
REQ-031 Random i_en toggling (50%) over 2 frames -> enabled-cycle output sequence identical to i_en=1 run; pulses never asserted while i_en=0.
REQ-032 Boundary at pos 419999 with i_en=1 -> next cycle o_pixel_pos=0, o_frame_start=1, o_line_start=1, o_blank=0.
REQ-033 i_rst pulsed at pos 200123 -> outputs take reset values next cycle; after release, sequence restarts at pos 0 with o_frame_start=1.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: walks an (h,v) position across the frame and
// presents registered sync, blank, linear pixel index and start pulses.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blank,
  output logic [20:0] o_pixel_pos,
  output logic        o_line_start,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Counters hold the position that the next enabled edge will present.
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [20:0] pix_cnt_q, pix_cnt_d;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic [20:0] pixel_pos_q, pixel_pos_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  logic h_last, v_last;

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    pixel_pos_d   = pixel_pos_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    h_last        = (h_cnt_q == H_LAST);
    v_last        = (v_cnt_q == V_LAST);

    if (i_en) begin
      hsync_d       = (h_cnt_q >= HS_BEG && h_cnt_q < HS_END) ? HS_POL : ~HS_POL;
      vsync_d       = (v_cnt_q >= VS_BEG && v_cnt_q < VS_END) ? VS_POL : ~VS_POL;
      blank_d       = !(h_cnt_q < H_ACT && v_cnt_q < V_ACT);
      pixel_pos_d   = pix_cnt_q;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
      // The linear index wraps on the same edge as the frame, never on its own.
      pix_cnt_d = (h_last && v_last) ? '0 : pix_cnt_q + 21'd1;
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_cnt_q     <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      blank_q       <= 1'b1;
      pixel_pos_q   <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      pixel_pos_q   <= pixel_pos_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_blank       = blank_q;
  assign o_pixel_pos   = pixel_pos_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

endmodule
